// File: rtl/lt_arbiter_pkg.sv
// Shared types and constants for the lt_arbiter shared less-than comparator.
// Optional unsigned compare support is enabled by defining LT_ARBITER_UNSIGNED_EN.
package lt_arb_pkg;

   localparam int LT_WIDTH = 16;
   localparam int NUM_REQ  = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMP  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_CMP  = ST_CMP,
      S_RESP = ST_RESP
   } state_e;

   typedef logic req_id_t;

   function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/lt_arbiter_if.sv
// Request/response bundle between the two requesters and lt_arbiter.
// LT_ARBITER_UNSIGNED_EN adds the per-requester req_uns select.
interface lt_arbiter_if
   import lt_arb_pkg::*;
#(
   parameter int WIDTH = LT_WIDTH
);
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   logic [WIDTH-1:0]   req_x0;
   logic [WIDTH-1:0]   req_y0;
   logic [WIDTH-1:0]   req_x1;
   logic [WIDTH-1:0]   req_y1;
   logic [NUM_REQ-1:0] resp_valid;
   logic [NUM_REQ-1:0] resp_ready;
   logic               resp_lt;
   logic               busy;
`ifdef LT_ARBITER_UNSIGNED_EN
   logic [NUM_REQ-1:0] req_uns;

   modport master (
      output req_valid, req_x0, req_y0, req_x1, req_y1, req_uns, resp_ready,
      input  req_ready, resp_valid, resp_lt, busy
   );
   modport slave (
      input  req_valid, req_x0, req_y0, req_x1, req_y1, req_uns, resp_ready,
      output req_ready, resp_valid, resp_lt, busy
   );
`else
   modport master (
      output req_valid, req_x0, req_y0, req_x1, req_y1, resp_ready,
      input  req_ready, resp_valid, resp_lt, busy
   );
   modport slave (
      input  req_valid, req_x0, req_y0, req_x1, req_y1, resp_ready,
      output req_ready, resp_valid, resp_lt, busy
   );
`endif
endinterface

// File: rtl/lt_arbiter_compare.sv
// Combinational less-than via X + ~Y + 1; signed result corrects for overflow.
// The unsigned (borrow) output exists only with LT_ARBITER_UNSIGNED_EN.
module lt_compare #(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] y_i,
`ifdef LT_ARBITER_UNSIGNED_EN
   output logic                    lt_unsigned_o,
`endif
   output logic                    lt_signed_o
);
   logic [WIDTH-1:0] diff;
   logic             ovf;

`ifdef LT_ARBITER_UNSIGNED_EN
   logic cout;
   assign {cout, diff} = {1'b0, x_i} + {1'b0, ~y_i} + (WIDTH+1)'(1);
   // No carry out of X + ~Y + 1 means a borrow occurred, i.e. X < Y unsigned.
   assign lt_unsigned_o = ~cout;
`else
   assign diff = x_i + ~y_i + WIDTH'(1);
`endif

   // Overflow only when operand signs differ and the result sign differs from X.
   assign ovf         = (x_i[WIDTH-1] ^ y_i[WIDTH-1]) & (diff[WIDTH-1] ^ x_i[WIDTH-1]);
   assign lt_signed_o = diff[WIDTH-1] ^ ovf;

endmodule

// File: rtl/lt_arbiter.sv
// Round-robin arbiter sharing one registered less-than comparator between two requesters.
// Define LT_ARBITER_UNSIGNED_EN to allow per-request unsigned compares.
module lt_arbiter
   import lt_arb_pkg::*;
#(
   parameter int WIDTH = LT_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   lt_arbiter_if.slave  bus
);
   state_e                    state_q, state_d;
   req_id_t                   last_q, last_d;
   req_id_t                   owner_q, owner_d;
   logic signed [WIDTH-1:0]   x_q, x_d;
   logic signed [WIDTH-1:0]   y_q, y_d;
   logic                      result_q, result_d;
   req_id_t                   grant;
   logic [NUM_REQ-1:0]        ready;
   logic                      take;
   logic                      lt_s;
`ifdef LT_ARBITER_UNSIGNED_EN
   logic                      uns_q, uns_d;
   logic                      lt_u;
`endif

   lt_compare #(.WIDTH(WIDTH)) u_cmp (
      .x_i           (x_q),
      .y_i           (y_q),
`ifdef LT_ARBITER_UNSIGNED_EN
      .lt_unsigned_o (lt_u),
`endif
      .lt_signed_o   (lt_s)
   );

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant = 1'b0;
      case (bus.req_valid)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_q;
         default: grant = 1'b0;
      endcase
   end

   assign ready = (state_q == S_IDLE && !rst && |bus.req_valid) ? id_onehot(grant) : '0;
   assign take  = |(bus.req_valid & ready);

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      x_d      = x_q;
      y_d      = y_q;
      result_d = result_q;
`ifdef LT_ARBITER_UNSIGNED_EN
      uns_d    = uns_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (take) begin
               x_d     = grant ? bus.req_x1 : bus.req_x0;
               y_d     = grant ? bus.req_y1 : bus.req_y0;
               owner_d = grant;
               last_d  = grant;
`ifdef LT_ARBITER_UNSIGNED_EN
               uns_d   = bus.req_uns[grant];
`endif
               state_d = S_CMP;
            end
         end
         S_CMP: begin
`ifdef LT_ARBITER_UNSIGNED_EN
            result_d = uns_q ? lt_u : lt_s;
`else
            result_d = lt_s;
`endif
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (bus.resp_ready[owner_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         result_q <= 1'b0;
`ifdef LT_ARBITER_UNSIGNED_EN
         uns_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         x_q      <= x_d;
         y_q      <= y_d;
         result_q <= result_d;
`ifdef LT_ARBITER_UNSIGNED_EN
         uns_q    <= uns_d;
`endif
      end
   end

   // Outputs forced low while rst is asserted so a discarded transaction never shows.
   assign bus.req_ready  = ready;
   assign bus.resp_valid = (state_q == S_RESP && !rst) ? id_onehot(owner_q) : '0;
   assign bus.resp_lt    = (state_q == S_RESP && !rst) & result_q;
   assign bus.busy       = (state_q != S_IDLE) && !rst;

endmodule
